// File: rtl/cga_pkg.sv
// Shared definitions for the CGA VRAM ISA port: FSM states, VRAM width and
// the sequencer step numbers that bound the ISA access windows.
package cga_pkg;

  localparam int VRAM_ADDR_WIDTH = 14;

  // First and last sequencer steps on which an ISA operation may begin OP1.
  localparam int ISA_WIN0_START = 5;
  localparam int ISA_WIN0_END   = 14;
  localparam int ISA_WIN1_START = 21;
  localparam int ISA_WIN1_END   = 30;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SLOT,
    OP1,
    OP2,
    OP3,
    DONE
  } isa_state_e;

endpackage

// File: rtl/cga_strobe_sync.sv
// N-stage synchronizer for an active-low asynchronous strobe, with a
// one-cycle pulse on the synchronized falling edge.
module cga_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe_n,
  output logic sync_n,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev_n;

  // Reset to the idle (high) level so a strobe held low across reset
  // release still produces an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain  <= '1;
      prev_n <= 1'b1;
    end else begin
      chain  <= {chain[STAGES-2:0], strobe_n};
      prev_n <= chain[STAGES-1];
    end
  end

  assign sync_n = chain[STAGES-1];
  assign fall   = prev_n & ~sync_n;

endmodule

// File: rtl/cga_vram_isa_port.sv
// ISA MEMR/MEMW to VRAM bridge: waits for a sequencer slot, runs a 3-cycle
// VRAM access and holds IOCHRDY low meanwhile. ISA_WRITE_POST_EN adds a
// one-entry posted-write buffer.
module cga_vram_isa_port
  import cga_pkg::*;
#(
  parameter int ADDR_WIDTH  = VRAM_ADDR_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_memr_n,
  input  logic                  bus_memw_n,
  input  logic [ADDR_WIDTH-1:0] bus_a,
  input  logic [7:0]            bus_d_in,
  output logic [7:0]            bus_d_out,
  output logic                  bus_d_oe,
  output logic                  bus_rdy,
  input  logic                  isa_op_enable,
  output logic                  isa_active,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  output logic [7:0]            vram_dout,
  input  logic [7:0]            vram_din,
  output logic                  vram_oe,
  output logic                  vram_we,
  output isa_state_e            dbg_state
);

  logic memr_n_s, memw_n_s, rd_req, wr_req;
  logic rd_start, wr_start, op_strobe_n;

  isa_state_e            state;
  logic                  op_read;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [7:0]            op_data;
`ifdef ISA_WRITE_POST_EN
  logic posted, pend_valid, pend_read;
`endif

  cga_strobe_sync #(.STAGES(SYNC_STAGES)) u_memr_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_n (bus_memr_n),
    .sync_n   (memr_n_s),
    .fall     (rd_req)
  );

  cga_strobe_sync #(.STAGES(SYNC_STAGES)) u_memw_sync (
    .clk      (clk),
    .reset    (reset),
    .strobe_n (bus_memw_n),
    .sync_n   (memw_n_s),
    .fall     (wr_req)
  );

  // A request only counts while the other strobe is high; both low is ignored.
  assign rd_start    = rd_req & memw_n_s;
  assign wr_start    = wr_req & memr_n_s;
  assign op_strobe_n = op_read ? memr_n_s : memw_n_s;
  assign dbg_state   = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op_read    <= 1'b0;
      op_addr    <= '0;
      op_data    <= 8'h00;
      bus_rdy    <= 1'b1;
      bus_d_oe   <= 1'b0;
      bus_d_out  <= 8'h00;
      isa_active <= 1'b0;
      vram_oe    <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_dout  <= 8'h00;
`ifdef ISA_WRITE_POST_EN
      posted     <= 1'b0;
      pend_valid <= 1'b0;
      pend_read  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus_d_oe <= 1'b0;
          if (rd_start) begin
            op_read <= 1'b1;
            op_addr <= bus_a;
            bus_rdy <= 1'b0;
            state   <= WAIT_SLOT;
          end else if (wr_start) begin
            op_read <= 1'b0;
            op_addr <= bus_a;
            op_data <= bus_d_in;
            state   <= WAIT_SLOT;
`ifdef ISA_WRITE_POST_EN
            posted  <= 1'b1;
`else
            bus_rdy <= 1'b0;
`endif
          end
        end
        WAIT_SLOT: begin
          if (isa_op_enable) begin
            state      <= OP1;
            isa_active <= 1'b1;
            vram_addr  <= op_addr;
            vram_oe    <= op_read;
            vram_dout  <= op_read ? 8'h00 : op_data;
          end
        end
        OP1: begin
          state   <= OP2;
          vram_we <= ~op_read;
        end
        OP2: begin
          state   <= OP3;
          vram_oe <= 1'b0;
          vram_we <= 1'b0;
        end
        OP3: begin
          isa_active <= 1'b0;
          vram_addr  <= '0;
          vram_dout  <= 8'h00;
          if (op_read) bus_d_out <= vram_din;
`ifdef ISA_WRITE_POST_EN
          // A drained posted write hands over straight to any waiting request.
          if (posted) begin
            posted     <= 1'b0;
            pend_valid <= 1'b0;
            if (pend_valid || rd_start || wr_start) begin
              op_read <= pend_valid ? pend_read : rd_start;
              op_addr <= bus_a;
              op_data <= bus_d_in;
              bus_rdy <= 1'b0;
              state   <= WAIT_SLOT;
            end else begin
              state <= IDLE;
            end
          end else
`endif
          begin
            bus_rdy <= 1'b1;
            if (op_strobe_n) begin
              state <= IDLE;
            end else begin
              state    <= DONE;
              bus_d_oe <= op_read;
            end
          end
        end
        DONE: begin
          if (op_strobe_n) begin
            state    <= IDLE;
            bus_d_oe <= 1'b0;
          end else begin
            bus_d_oe <= op_read;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef ISA_WRITE_POST_EN
      if (posted && !pend_valid && (rd_start || wr_start) &&
          (state == WAIT_SLOT || state == OP1 || state == OP2)) begin
        pend_valid <= 1'b1;
        pend_read  <= rd_start;
        bus_rdy    <= 1'b0;
      end
`endif
    end
  end

endmodule
